// File: rtl/leitor_campos_bcd.sv
// leitor_campos_bcd: multi-field decimal keypad entry. Collects N_CAMPOS fields
// of up to N_DIGITOS BCD digits, converts each to binary with a one-digit-per-
// cycle Horner pass, then waits for the external classifier and shows its result.
module leitor_campos_bcd #(
    parameter int N_CAMPOS   = 7,
    parameter int N_DIGITOS  = 4,
    parameter int LARG_VALOR = 14,
    parameter int LARG_CAMPO = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [9:0]                     IO,
    input  logic                           clear,
    input  logic                           prox,
    input  logic                           apagar,
    input  logic                           resultado_valido,
    input  logic [3:0]                     resultado_in,
    output logic [LARG_CAMPO-1:0]          campo,
    output logic [4*N_DIGITOS-1:0]         digitos,
    output logic [N_CAMPOS*LARG_VALOR-1:0] valores,
    output logic                           ocupado,
    output logic                           pronto,
    output logic [3:0]                     resultado,
    output logic                           erro
);

    localparam int LARG_POS = $clog2(N_DIGITOS + 1);
    localparam int LARG_DIG = 4 * N_DIGITOS;

    typedef enum logic [1:0] {ENTRADA, CONVERTE, AGUARDA, RESULTADO} estado_t;

    estado_t                     estado_q, estado_d;
    logic [LARG_CAMPO-1:0]       campo_q, campo_d;
    logic [LARG_DIG-1:0]         digitos_q, digitos_d;
    logic [N_CAMPOS*LARG_VALOR-1:0] valores_q, valores_d;
    logic [LARG_POS-1:0]         pos_q, pos_d;
    logic [LARG_POS-1:0]         cnt_q, cnt_d;
    logic [LARG_VALOR-1:0]       acc_q, acc_d;
    logic [3:0]                  resultado_q, resultado_d;
    logic                        erro_q, erro_d;
    logic [9:0]                  io_q, io_d;
    logic                        clear_q, clear_d;
    logic                        prox_q, prox_d;
    logic                        apagar_q, apagar_d;

    logic [9:0]                  sobe_io;
    logic                        sobe_clear, sobe_prox, sobe_apagar;
    logic                        limpa;
    logic [3:0]                  digito_tecla;
    logic [3:0]                  digito_conv;
    logic [LARG_VALOR-1:0]       acc_prox;

    assign sobe_io     = IO & ~io_q;
    assign sobe_clear  = clear & ~clear_q;
    assign sobe_prox   = prox & ~prox_q;
    assign sobe_apagar = apagar & ~apagar_q;

    // Full clear: clear edge anywhere, or prox edge while the result is shown.
    assign limpa = sobe_clear | ((estado_q == RESULTADO) & sobe_prox);

    // Decode the pressed key and pick the nibble for the current Horner step.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        digito_tecla = '0;
        digito_conv  = '0;
        for (int i = 0; i < 10; i++) begin
            if (sobe_io[i]) digito_tecla = 4'(i);
        end
        // Most significant nibble is consumed first (cnt_q == 0).
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (cnt_q == LARG_POS'(N_DIGITOS - 1 - i)) digito_conv = digitos_q[4*i +: 4];
        end
        acc_prox = acc_q * LARG_VALOR'(10) + LARG_VALOR'(digito_conv);
    end

    // Next-state and datapath update, priority clear > prox > apagar > key.
    always_comb begin
        estado_d    = estado_q;
        campo_d     = campo_q;
        digitos_d   = digitos_q;
        valores_d   = valores_q;
        pos_d       = pos_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        resultado_d = resultado_q;
        erro_d      = erro_q;
        io_d        = IO;
        clear_d     = clear;
        prox_d      = prox;
        apagar_d    = apagar;

        if (limpa) begin
            // Same as reset, including the edge registers; a conversion in
            // flight is dropped without writing its field.
            estado_d    = ENTRADA;
            campo_d     = '0;
            digitos_d   = '0;
            valores_d   = '0;
            pos_d       = '0;
            cnt_d       = '0;
            acc_d       = '0;
            resultado_d = '0;
            erro_d      = 1'b0;
            io_d        = '0;
            clear_d     = 1'b0;
            prox_d      = 1'b0;
            apagar_d    = 1'b0;
        end else begin
            unique case (estado_q)
                ENTRADA: begin
                    if (sobe_prox) begin
                        estado_d = CONVERTE;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else if (sobe_apagar) begin
                        if (pos_q != '0) begin
                            digitos_d = digitos_q >> 4;
                            pos_d     = pos_q - LARG_POS'(1);
                        end
                    end else if (sobe_io != '0) begin
                        if (($countones(sobe_io) == 1) && (pos_q < LARG_POS'(N_DIGITOS))) begin
                            digitos_d = (digitos_q << 4) | LARG_DIG'(digito_tecla);
                            pos_d     = pos_q + LARG_POS'(1);
                        end else begin
                            erro_d = 1'b1;
                        end
                    end
                end
                CONVERTE: begin
                    acc_d = acc_prox;
                    cnt_d = cnt_q + LARG_POS'(1);
                    if (cnt_q == LARG_POS'(N_DIGITOS - 1)) begin
                        for (int i = 0; i < N_CAMPOS; i++) begin
                            if (campo_q == LARG_CAMPO'(i)) valores_d[i*LARG_VALOR +: LARG_VALOR] = acc_prox;
                        end
                        digitos_d = '0;
                        pos_d     = '0;
                        cnt_d     = '0;
                        if (campo_q < LARG_CAMPO'(N_CAMPOS - 1)) begin
                            campo_d  = campo_q + LARG_CAMPO'(1);
                            estado_d = ENTRADA;
                        end else begin
                            campo_d  = LARG_CAMPO'(N_CAMPOS);
                            estado_d = AGUARDA;
                        end
                    end
                end
                AGUARDA: begin
                    if (resultado_valido) begin
                        resultado_d = resultado_in;
                        estado_d    = RESULTADO;
                    end
                end
                RESULTADO: begin
                    // Only a full clear leaves this state.
                end
                default: estado_d = ENTRADA;
            endcase
        end
    end

    // State and data registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            estado_q    <= ENTRADA;
            campo_q     <= '0;
            digitos_q   <= '0;
            // NOTE: the committed-value bank is plain flops and is visible on
            // the outputs, so it is reset along with everything else.
            valores_q   <= '0;
            pos_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            resultado_q <= '0;
            erro_q      <= 1'b0;
            io_q        <= '0;
            clear_q     <= 1'b0;
            prox_q      <= 1'b0;
            apagar_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            campo_q     <= campo_d;
            digitos_q   <= digitos_d;
            valores_q   <= valores_d;
            pos_q       <= pos_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            resultado_q <= resultado_d;
            erro_q      <= erro_d;
            io_q        <= io_d;
            clear_q     <= clear_d;
            prox_q      <= prox_d;
            apagar_q    <= apagar_d;
        end
    end

    assign campo     = campo_q;
    assign digitos   = (estado_q == RESULTADO) ? LARG_DIG'(resultado_q) : digitos_q;
    assign valores   = valores_q;
    assign ocupado   = (estado_q == CONVERTE);
    assign pronto    = (estado_q == AGUARDA);
    assign resultado = resultado_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_leitor_campos_bcd.sv
// Testbench for leitor_campos_bcd: a driver applies stimulus at the falling
// edge and pushes the expected post-edge outputs from a decimal-level model;
// a monitor pops and compares one snapshot per cycle just after the rising edge.
module tb_leitor_campos_bcd;

    localparam int NC = 7;
    localparam int ND = 4;
    localparam int LV = 14;
    localparam int LC = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [9:0]        IO = '0;
    logic              clear = 1'b0;
    logic              prox = 1'b0;
    logic              apagar = 1'b0;
    logic              resultado_valido = 1'b0;
    logic [3:0]        resultado_in = '0;
    logic [LC-1:0]     campo;
    logic [4*ND-1:0]   digitos;
    logic [NC*LV-1:0]  valores;
    logic              ocupado;
    logic              pronto;
    logic [3:0]        resultado;
    logic              erro;

    leitor_campos_bcd #(
        .N_CAMPOS  (NC),
        .N_DIGITOS (ND),
        .LARG_VALOR(LV),
        .LARG_CAMPO(LC)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .IO              (IO),
        .clear           (clear),
        .prox            (prox),
        .apagar          (apagar),
        .resultado_valido(resultado_valido),
        .resultado_in    (resultado_in),
        .campo           (campo),
        .digitos         (digitos),
        .valores         (valores),
        .ocupado         (ocupado),
        .pronto          (pronto),
        .resultado       (resultado),
        .erro            (erro)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [LC-1:0]    campo;
        logic [4*ND-1:0]  digitos;
        logic [NC*LV-1:0] valores;
        logic             ocupado;
        logic             pronto;
        logic [3:0]       resultado;
        logic             erro;
    } snap_t;

    snap_t esperado_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string nome, input logic [63:0] real_v, input logic [63:0] esp_v);
        n_checks++;
        if (real_v !== esp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, real_v, esp_v, $time);
        end
    endtask

    // ---------------- reference model (decimal level) ----------------
    typedef enum int {M_ENTRADA, M_CONVERTE, M_AGUARDA, M_RESULTADO} modo_t;
    modo_t      m_modo;
    int         m_digs[$];      // entered digits, oldest first
    int         m_campo;
    int         m_vals[NC];
    int         m_restantes;    // conversion cycles left
    int         m_pend;         // value the running conversion will write
    int         m_res;
    bit         m_erro;
    logic [9:0] m_io_ant;
    bit         m_clear_ant, m_prox_ant, m_apagar_ant;

    task automatic model_reset();
        m_modo = M_ENTRADA;
        m_digs.delete();
        m_campo = 0;
        foreach (m_vals[i]) m_vals[i] = 0;
        m_restantes = 0;
        m_pend = 0;
        m_res = 0;
        m_erro = 0;
        m_io_ant = '0;
        m_clear_ant = 0;
        m_prox_ant = 0;
        m_apagar_ant = 0;
    endtask

    function automatic int valor_decimal();
        int v = 0;
        foreach (m_digs[i]) v = v * 10 + m_digs[i];
        return v % (1 << LV);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [9:0] r_io;
        bit r_cl, r_px, r_ap;
        if (reset) begin
            model_reset();
            return;
        end
        r_io = IO & ~m_io_ant;
        r_cl = clear && !m_clear_ant;
        r_px = prox && !m_prox_ant;
        r_ap = apagar && !m_apagar_ant;
        m_io_ant = IO;
        m_clear_ant = clear;
        m_prox_ant = prox;
        m_apagar_ant = apagar;
        if (r_cl || (m_modo == M_RESULTADO && r_px)) begin
            model_reset();
            return;
        end
        case (m_modo)
            M_ENTRADA: begin
                if (r_px) begin
                    m_modo = M_CONVERTE;
                    m_restantes = ND;
                    m_pend = valor_decimal();
                end else if (r_ap) begin
                    if (m_digs.size() > 0) void'(m_digs.pop_back());
                end else if (r_io != '0) begin
                    if ($countones(r_io) == 1 && m_digs.size() < ND) begin
                        for (int i = 0; i < 10; i++) if (r_io[i]) m_digs.push_back(i);
                    end else begin
                        m_erro = 1;
                    end
                end
            end
            M_CONVERTE: begin
                m_restantes--;
                if (m_restantes == 0) begin
                    m_vals[m_campo] = m_pend;
                    m_digs.delete();
                    if (m_campo < NC - 1) begin
                        m_campo++;
                        m_modo = M_ENTRADA;
                    end else begin
                        m_campo = NC;
                        m_modo = M_AGUARDA;
                    end
                end
            end
            M_AGUARDA: begin
                if (resultado_valido) begin
                    m_res = int'(resultado_in);
                    m_modo = M_RESULTADO;
                end
            end
            default: ;
        endcase
    endtask

    function automatic snap_t snapshot();
        snap_t s;
        logic [4*ND-1:0] pack = '0;
        foreach (m_digs[i]) pack = (pack << 4) | (4*ND)'(m_digs[i]);
        s.campo   = LC'(m_campo);
        s.digitos = (m_modo == M_RESULTADO) ? (4*ND)'(m_res) : pack;
        s.valores = '0;
        for (int i = 0; i < NC; i++) s.valores[i*LV +: LV] = LV'(m_vals[i]);
        s.ocupado   = (m_modo == M_CONVERTE);
        s.pronto    = (m_modo == M_AGUARDA);
        s.resultado = 4'(m_res);
        s.erro      = m_erro;
        return s;
    endfunction

    // ---------------- driver helpers ----------------
    task automatic drive(input logic [9:0] io_v = '0, input bit cl = 0, input bit px = 0,
                         input bit ap = 0, input bit rv = 0, input logic [3:0] rin = '0,
                         input bit rst = 0);
        @(negedge clock);
        reset = rst;
        IO = io_v;
        clear = cl;
        prox = px;
        apagar = ap;
        resultado_valido = rv;
        resultado_in = rin;
        model_step();
        esperado_q.push_back(snapshot());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive();
    endtask

    task automatic tecla(input int d);
        logic [9:0] v;
        v = 10'(1) << d;
        drive(v);
        drive();
    endtask

    task automatic pulso_prox();
        drive('0, 0, 1);
        drive();
    endtask

    task automatic pulso_apagar();
        drive('0, 0, 0, 1);
        drive();
    endtask

    task automatic pulso_clear();
        drive('0, 1);
        drive();
    endtask

    // ---------------- monitor ----------------
    // Compares the DUT against the oldest expected snapshot after each rising edge.
    initial begin
        snap_t e;
        forever begin
            @(posedge clock);
            #1;
            if (esperado_q.size() > 0) begin
                e = esperado_q.pop_front();
                check("campo", 64'(campo), 64'(e.campo));
                check("digitos", 64'(digitos), 64'(e.digitos));
                for (int i = 0; i < NC; i++)
                    check($sformatf("valores[%0d]", i), 64'(valores[i*LV +: LV]), 64'(e.valores[i*LV +: LV]));
                check("ocupado", 64'(ocupado), 64'(e.ocupado));
                check("pronto", 64'(pronto), 64'(e.pronto));
                check("resultado", 64'(resultado), 64'(e.resultado));
                check("erro", 64'(erro), 64'(e.erro));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] io_r;
        model_reset();
        drive('0, 0, 0, 0, 0, '0, 1);
        drive('0, 0, 0, 0, 0, '0, 1);
        idle(2);

        // Enter 120 and commit it to field 0.
        tecla(1);
        tecla(2);
        tecla(0);
        check("dir_digitos_0120", 64'(digitos), 64'h0120);
        pulso_prox();
        idle(ND + 1);
        check("dir_campo_1", 64'(campo), 64'd1);
        check("dir_valor0_120", 64'(valores[0 +: LV]), 64'd120);

        // Backspace mid-entry, then backspace at position 0.
        tecla(4);
        tecla(7);
        pulso_apagar();
        tecla(3);
        check("dir_digitos_0043", 64'(digitos), 64'h0043);
        pulso_prox();
        idle(ND + 1);
        check("dir_valor1_43", 64'(valores[LV +: LV]), 64'd43);
        pulso_apagar();
        check("dir_apagar_vazio", 64'(digitos), 64'h0);
        check("dir_apagar_sem_erro", 64'(erro), 64'd0);

        // Fill the field, overflow key sets erro, commit 9999.
        for (int i = 0; i < ND; i++) tecla(9);
        tecla(5);
        check("dir_digitos_9999", 64'(digitos), 64'h9999);
        check("dir_erro_cheio", 64'(erro), 64'd1);
        pulso_prox();
        idle(ND + 1);
        check("dir_valor2_9999", 64'(valores[2*LV +: LV]), 64'd9999);

        // Clear, then two keys in one cycle, then key together with prox.
        pulso_clear();
        check("dir_clear_erro", 64'(erro), 64'd0);
        check("dir_clear_valores", 64'(valores), 64'd0);
        drive(10'b00_0000_1100);
        drive();
        check("dir_multi_erro", 64'(erro), 64'd1);
        check("dir_multi_digitos", 64'(digitos), 64'h0);
        drive(10'b00_0010_0000, 0, 1);
        drive();
        idle(ND + 1);
        check("dir_prox_vence_campo", 64'(campo), 64'd1);
        check("dir_prox_vence_valor0", 64'(valores[0 +: LV]), 64'd0);

        // Seven fields 1..7, classifier result, prox back to reset values.
        pulso_clear();
        for (int v = 1; v <= NC; v++) begin
            tecla(v);
            pulso_prox();
            idle(ND + 1);
        end
        check("dir_pronto", 64'(pronto), 64'd1);
        check("dir_campo_final", 64'(campo), 64'd7);
        drive('0, 0, 0, 0, 1, 4'h1);
        drive();
        check("dir_resultado", 64'(resultado), 64'd1);
        check("dir_digitos_resultado", 64'(digitos), 64'h0001);
        check("dir_pronto_baixo", 64'(pronto), 64'd0);
        pulso_prox();
        check("dir_volta_campo", 64'(campo), 64'd0);
        check("dir_volta_valores", 64'(valores), 64'd0);
        check("dir_volta_resultado", 64'(resultado), 64'd0);

        // Clear during the second conversion cycle aborts without a write.
        tecla(8);
        drive('0, 0, 1);
        drive();
        drive('0, 1);
        drive();
        check("dir_aborto_valores", 64'(valores), 64'd0);
        check("dir_aborto_ocupado", 64'(ocupado), 64'd0);
        idle(ND + 1);
        check("dir_aborto_campo", 64'(campo), 64'd0);

        // Holding prox for ten cycles yields exactly one advance.
        tecla(6);
        for (int i = 0; i < 10; i++) drive('0, 0, 1);
        drive();
        idle(ND + 1);
        check("dir_prox_seguro_campo", 64'(campo), 64'd1);
        check("dir_prox_seguro_valor", 64'(valores[0 +: LV]), 64'd6);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int r;
            io_r = '0;
            r = int'($urandom_range(0, 99));
            if (r < 14) io_r = 10'(1) << $urandom_range(0, 9);
            else if (r < 17) io_r = (10'(1) << $urandom_range(0, 9)) | (10'(1) << $urandom_range(0, 9));
            drive(io_r,
                  $urandom_range(0, 199) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 499) == 0);
        end

        idle(2);
        for (int i = 0; i < 5 && esperado_q.size() > 0; i++) @(posedge clock);
        #2;
        check("fila_vazia", 64'(esperado_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/leitor_campos_bcd.md
# leitor_campos_bcd

Parametrised multi-field decimal entry controller for the screening front panel. It takes a one-hot 10-key keypad plus `clear`, `prox` and `apagar` buttons and collects `N_CAMPOS` decimal fields of up to `N_DIGITOS` digits each. Each field is converted to binary with a sequential Horner pass, and the block then hands all values to the external classifier and latches its result for display. It drives the BCD digit bus feeding the existing `bcd7seg` decoders.

## Interface
- `N_CAMPOS`, default 7: number of input fields.
- `N_DIGITOS`, default 4: maximum decimal digits per field.
- `LARG_VALOR`, default 14: binary width per field; must satisfy 2^LARG_VALOR > 10^N_DIGITOS − 1.
- `LARG_CAMPO`, default 3: width of the field index; must satisfy 2^LARG_CAMPO > N_CAMPOS.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `IO` in 10: keypad keys 0..9 as levels; bit d = key d.
- `clear` in 1: abort entry and restart (level).
- `prox` in 1: commit the current field and advance (level).
- `apagar` in 1: backspace (level).
- `resultado_valido` in 1: classifier result strobe.
- `resultado_in` in 4: classifier result, sampled when the strobe is high.
- `campo` out LARG_CAMPO: current field index; equals N_CAMPOS in the result state.
- `digitos` out 4*N_DIGITOS: BCD digits of the current field; [3:0] is the most recently entered digit, right-aligned.
- `valores` out N_CAMPOS*LARG_VALOR: committed binary values; field i occupies [i*LARG_VALOR +: LARG_VALOR].
- `ocupado` out 1: high while a conversion is in progress.
- `pronto` out 1: all fields committed, waiting for the classifier.
- `resultado` out 4: latched classifier result.
- `erro` out 1: sticky; set by a multi-key press or by a key pressed when the field is full.

## Operation
- Edge detection: `IO`, `clear`, `prox` and `apagar` are registered every cycle. An action fires on a 0→1 transition only. Holding a button produces exactly one action.
- Priority within a cycle: `reset` > `clear` > `prox` > `apagar` > key. Lower-priority edges in the same cycle are discarded, not queued.
- FSM states:
  - ENTRADA: accepts keys, `apagar` and `prox`.
  - CONVERTE: keys, `prox` and `apagar` are ignored.
  - AGUARDA: `pronto`=1; waits for `resultado_valido`.
  - RESULTADO: `digitos` shows `resultado` in digit 0 with all other digits 0.
- Key in ENTRADA:
  - Exactly one rising `IO` bit and position < N_DIGITOS: shift the digits left by one nibble, insert d at [3:0], position+1.
  - More than one rising bit, or position == N_DIGITOS: no change, `erro`←1.
- `apagar` in ENTRADA with position > 0: shift the digits right by one nibble, zero the top nibble, position−1. At position 0 it does nothing.
- `prox` in ENTRADA → CONVERTE with acc=0. Each CONVERTE cycle processes one stored digit, most significant first: acc←acc*10+digit, truncated to LARG_VALOR. Unused leading nibbles are 0, so all N_DIGITOS nibbles are always processed.
- Last CONVERTE cycle:
  - Write acc to `valores` field `campo`, clear the digits and position.
  - If `campo` < N_CAMPOS−1: `campo`+1 and go to ENTRADA.
  - Otherwise: `campo`←N_CAMPOS and go to AGUARDA.
- `prox` with 0 digits entered commits the value 0.
- AGUARDA: a cycle with `resultado_valido`=1 latches `resultado_in` into `resultado` and goes to RESULTADO. `prox` is ignored in AGUARDA.
- RESULTADO: a `prox` edge or a `clear` edge performs the full clear.
- Full clear (from `clear`, or from `prox` in RESULTADO): identical to reset, in any state, including mid-CONVERTE, which is aborted with no write.
- Reset values: state ENTRADA, `campo`=0, `digitos`=0, `valores`=0, `ocupado`=0, `pronto`=0, `resultado`=0, `erro`=0, and the edge registers = 0.
- Edge-register reset caveat: an input already high when reset is released counts as a rising edge on the first cycle.

## Timing
- Key, `apagar` or `clear` level first high before clock edge k: the effect is visible after edge k (one cycle of latency).
- `prox` seen at edge k:
  - `ocupado`=1 from after edge k until after edge k+N_DIGITOS, i.e. exactly N_DIGITOS cycles.
  - `valores` and `campo` update, and `ocupado` falls, after edge k+N_DIGITOS.
- `pronto` rises with the final `campo` update and falls after the edge that samples `resultado_valido`=1. `resultado` is valid from that same edge.
- `erro` clears only on reset or full clear.

## Test plan
- Defaults; press 1,2,0 then `prox` → `digitos`=0x0120 after the third key; `ocupado` high for 4 cycles; field 0 = 120; `campo`=1.
- Press 9 four times, then press 5 → `digitos`=0x9999, `erro`=1, no change; `prox` → field = 9999.
- Press 4,7, `apagar`, 3 → `digitos`=0x0043; `apagar` at position 0 → no change and no `erro`.
- Press keys 2 and 3 in the same cycle → no digit entered, `erro`=1. Press 5 with `prox` in the same cycle → only `prox` acts; a field with no digits entered commits 0.
- Commit 7 fields (values 1..7) → `pronto`=1, `campo`=7; `resultado_valido` with 4'h1 → `resultado`=1, `digitos`=0x0001; `prox` → all outputs return to reset values.
- `clear` asserted in the 2nd CONVERTE cycle → reset values next cycle and the field is not written. Hold `prox` for 10 cycles → exactly one advance.
